tt_um_serial_subtractor: RTL and testbench

//  Bit-serial 4-bit subtractor tile: computes A-B LSB-first, one bit per clock.

---
 rtl/sub_pkg.sv | 22 ++
 rtl/half_sub.sv | 12 +
 rtl/tt_um_serial_subtractor.sv | 119 +++++++++++
 tb/tb_tt_um_serial_subtractor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor tile.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SHOW
  } state_t;

  // Active-high a..g segment patterns for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam int unsigned START_BIT = 0;
  localparam int unsigned BUSY_BIT  = 1;
  localparam int unsigned DONE_BIT  = 2;

  localparam logic [7:0] UIO_OE_VAL = 8'b0000_0110;

endpackage

// File: rtl/half_sub.sv
// Single-bit half subtractor: diff = a - b, bout set when a borrow is needed.
module half_sub (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b;
  assign bout = ~a & b;

endmodule

// File: rtl/tt_um_serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, result shown as a hex digit with DP as borrow.
module tt_um_serial_subtractor
  import sub_pkg::*;
#(
  parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
  parameter int unsigned WIDTH     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state;
  logic [2:0]        sync;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-2:0]  res;
  logic              bor;
  logic [CntW-1:0]   cnt;
  logic [23:0]       hold;
  logic [WIDTH:0]    disp_reg;
  logic              busy;
  logic              done;

  logic start_pulse;
  logic d1, bo1, d, bo2, bor_nx;
  logic unused_uio;

  assign start_pulse = sync[1] & ~sync[2] & ena;
  assign unused_uio  = ^uio_in[7:1];

  // Two half subtractors chained through the borrow flop form one full-subtract step.
  half_sub u_hs_ab (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .diff (d1),
    .bout (bo1)
  );

  half_sub u_hs_bor (
    .a    (d1),
    .b    (bor),
    .diff (d),
    .bout (bo2)
  );

  assign bor_nx = bo1 | bo2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res      <= '0;
      bor      <= 1'b0;
      cnt      <= '0;
      hold     <= '0;
      disp_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      sync <= {sync[1:0], uio_in[START_BIT]};
      unique case (state)
        IDLE: begin
          if (start_pulse) begin
            op_a  <= ui_in[WIDTH-1:0];
            op_b  <= ui_in[2*WIDTH-1:WIDTH];
            bor   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          op_a <= op_a >> 1;
          op_b <= op_b >> 1;
          res  <= {d, res[WIDTH-2:1]};
          bor  <= bor_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            // Final bit goes straight to the display; res holds the lower bits.
            disp_reg <= {bor_nx, d, res};
            hold     <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= SHOW;
          end
        end
        SHOW: begin
          hold <= hold + 24'd1;
          if (hold == MAX_COUNT - 24'd1) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign uo_out = {disp_reg[WIDTH], SEG_HEX[disp_reg[WIDTH-1:0]]};

  always_comb begin
    uio_out           = '0;
    uio_out[BUSY_BIT] = busy;
    uio_out[DONE_BIT] = done;
  end

  assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// Directed bench for the serial subtractor tile with MAX_COUNT shortened to 8.
module tb_tt_um_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_uo;
  } vec_t;

  vec_t vecs [10];

  tt_um_serial_subtractor #(
    .MAX_COUNT (24'd8),
    .WIDTH     (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // One rising edge passes; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Step n cycles with start high in [on1,off1) and [on2,off2); optional ui_in change
  // and ena drop from given steps. Step 1 contains E0 when on1==1.
  task automatic observe(input int n, input int on1, input int off1, input int on2,
                         input int off2, input int chg_step, input logic [7:0] chg_val,
                         input int ena_off, output int busy_c, output int busy_r,
                         output int done_c, output int first_done);
    logic prev_busy;
    busy_c = 0;
    busy_r = 0;
    done_c = 0;
    first_done = 0;
    prev_busy = uio_out[1];
    for (int i = 1; i <= n; i++) begin
      uio_in[0] = ((i >= on1) && (i < off1)) || ((i >= on2) && (i < off2));
      if (chg_step != 0 && i == chg_step) ui_in = chg_val;
      if (ena_off != 0 && i >= ena_off) ena = 1'b0;
      step();
      if (uio_out[1] === 1'b1) busy_c++;
      if (uio_out[1] === 1'b1 && prev_busy !== 1'b1) busy_r++;
      prev_busy = uio_out[1];
      if (uio_out[2] === 1'b1) begin
        done_c++;
        if (first_done == 0) first_done = i;
      end
    end
    uio_in[0] = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                        input string name);
    int n;
    ui_in = {b, a};
    uio_in[0] = 1'b1;
    step();
    step();
    uio_in[0] = 1'b0;
    n = 0;
    while (uio_out[2] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (uio_out[2] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: got done=%b, expected 1", name, uio_out[2]);
    end else begin
      check(name, {24'd0, uo_out}, {24'd0, exp});
    end
    n = 0;
    while (uio_out[2] !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    step();
  endtask

  initial begin
    int bc, br, dc, fd;

    vecs[0] = '{4'h9, 4'h3, 8'h7D};
    vecs[1] = '{4'h3, 4'h5, 8'hF9};
    vecs[2] = '{4'hF, 4'hF, 8'h3F};
    vecs[3] = '{4'h0, 4'h1, 8'hF1};
    vecs[4] = '{4'h7, 4'h2, 8'h6D};
    vecs[5] = '{4'h0, 4'h0, 8'h3F};
    vecs[6] = '{4'h8, 4'h1, 8'h07};
    vecs[7] = '{4'hF, 4'h0, 8'h71};
    vecs[8] = '{4'h4, 4'hC, 8'hFF};
    vecs[9] = '{4'hA, 4'h3, 8'h07};

    // Reset state, then idle with no start.
    step();
    step();
    check("rst_uo_out", {24'd0, uo_out}, 32'h3F);
    check("rst_uio_out", {24'd0, uio_out}, 32'h00);
    check("rst_uio_oe", {24'd0, uio_oe}, 32'h06);
    rst_n = 1'b1;
    repeat (10) step();
    check("idle_uo_out", {24'd0, uo_out}, 32'h3F);
    check("idle_uio_out", {24'd0, uio_out}, 32'h00);

    // Latency and flag durations for 9-3.
    ui_in = 8'h39;
    observe(30, 1, 3, 0, 0, 0, 8'h00, 0, bc, br, dc, fd);
    check("lat_busy_cycles", bc, 4);
    check("lat_first_done", fd, 7);
    check("lat_done_cycles", dc, 8);
    check("lat_uo_out", {24'd0, uo_out}, 32'h7D);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_uo, $sformatf("vec%0d", i));

    // Held start gives one operation.
    ui_in = 8'h53;
    observe(80, 1, 51, 0, 0, 0, 8'h00, 0, bc, br, dc, fd);
    check("held_busy_rises", br, 1);
    check("held_done_cycles", dc, 8);
    check("held_uo_out", {24'd0, uo_out}, 32'hF9);

    // Second pulse during SHIFT ignored; operands changed after capture.
    ui_in = 8'h39;
    observe(40, 1, 3, 5, 7, 4, 8'hFF, 0, bc, br, dc, fd);
    check("shift_pulse_rises", br, 1);
    check("shift_pulse_done", dc, 8);
    check("shift_chg_uo_out", {24'd0, uo_out}, 32'h7D);

    // Second pulse during SHOW ignored.
    ui_in = 8'h53;
    observe(40, 1, 3, 10, 12, 0, 8'h00, 0, bc, br, dc, fd);
    check("show_pulse_rises", br, 1);
    check("show_pulse_done", dc, 8);
    check("show_pulse_uo_out", {24'd0, uo_out}, 32'hF9);

    // ena low blocks starts; display keeps the last result.
    ena = 1'b0;
    ui_in = 8'h39;
    observe(20, 1, 3, 0, 0, 0, 8'h00, 0, bc, br, dc, fd);
    check("ena_off_busy", bc, 0);
    check("ena_off_done", dc, 0);
    check("ena_off_uo_out", {24'd0, uo_out}, 32'hF9);
    ena = 1'b1;
    step();
    step();

    // ena dropped mid-SHIFT still completes the operation.
    ui_in = 8'h10;
    observe(30, 1, 3, 0, 0, 0, 8'h00, 5, bc, br, dc, fd);
    check("ena_drop_done", dc, 8);
    check("ena_drop_uo_out", {24'd0, uo_out}, 32'hF1);
    ena = 1'b1;
    step();

    // Asynchronous reset mid-SHIFT.
    ui_in = 8'h39;
    uio_in[0] = 1'b1;
    repeat (4) step();
    check("mid_shift_busy", {31'd0, uio_out[1]}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_uo_out", {24'd0, uo_out}, 32'h3F);
    check("async_rst_uio_out", {24'd0, uio_out}, 32'h00);
    uio_in[0] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_uo_out", {24'd0, uo_out}, 32'h3F);
    run_op(4'h9, 4'h3, 8'h7D, "post_rst_op");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
